// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite constants and interrupt controller register offsets
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Word offsets (haddr[4:2]) of the interrupt controller registers
    localparam logic [2:0] INTC_ENABLE  = 3'd0;
    localparam logic [2:0] INTC_TYPE    = 3'd1;
    localparam logic [2:0] INTC_PENDING = 3'd2;
    localparam logic [2:0] INTC_CLAIM   = 3'd3;
    localparam logic [2:0] INTC_CTRL    = 3'd4;

    localparam int INTC_ID_W = 5;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - lowest-index-wins priority encoder, returns bit index + 1 or 0 for none
module intc_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = 5
) (
    input  logic [N-1:0]    mask,
    output logic [ID_W-1:0] id
);

    // Scan from the top so the lowest set bit is the last assignment to stick
    always_comb begin
        id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) begin
                id = ID_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/ahb_intc.sv
// rtl/ahb_intc.sv - AHB-Lite interrupt controller with level/edge sources and claim/complete
module ahb_intc
    import ahb_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int NUM_IRQ = 8
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel_i,
    input  logic              hwrite_i,
    input  logic              hready_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    input  logic [1:0]        htrans_i,
    input  logic [DWIDTH-1:0] hwdata_i,
    input  logic [AWIDTH-1:0] haddr_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic [DWIDTH-1:0] hrdata_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic              irq_o
);

    logic                 dp_valid;
    logic                 dp_write;
    logic [2:0]           dp_off;
    logic [NUM_IRQ-1:0]   enable;
    logic [NUM_IRQ-1:0]   trig_type;
    logic [NUM_IRQ-1:0]   edge_pend;
    logic [NUM_IRQ-1:0]   src_d;
    logic                 ctrl_en;
    logic [INTC_ID_W-1:0] in_service;

    logic                 accept;
    logic                 rd_en;
    logic                 wr_en;
    logic [NUM_IRQ-1:0]   pending_vec;
    logic [INTC_ID_W-1:0] best_id;
    logic [INTC_ID_W-1:0] claim_val;
    logic                 claim_take;
    logic [NUM_IRQ-1:0]   set_mask;
    logic [NUM_IRQ-1:0]   clr_mask;
    logic [NUM_IRQ-1:0]   type_chg;
    logic [NUM_IRQ-1:0]   edge_next;
    logic                 unused_bits;

    assign hreadyout_o = 1'b1;
    assign hresp_o     = 1'b0;
    assign unused_bits = ^{hburst_i, haddr_i, hwdata_i, htrans_i[0]};

    assign accept = hsel_i & hready_i & htrans_i[1] & (hsize_i == HSIZE_WORD);
    assign rd_en  = dp_valid & ~dp_write;
    assign wr_en  = dp_valid & dp_write;

    assign pending_vec = (edge_pend & trig_type) | (irq_src_i & ~trig_type);

    intc_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (INTC_ID_W)
    ) u_prio (
        .mask (pending_vec & enable),
        .id   (best_id)
    );

    assign claim_val  = (in_service == '0) ? best_id : '0;
    assign claim_take = rd_en & (dp_off == INTC_CLAIM) & (claim_val != '0);

    // A new edge is ORed in after the claim clear so a coincident edge is not lost
    always_comb begin
        set_mask = irq_src_i & ~src_d & trig_type;
        clr_mask = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            clr_mask[k] = claim_take & (best_id == INTC_ID_W'(k + 1));
        end
        type_chg = '0;
        if (wr_en && dp_off == INTC_TYPE) begin
            type_chg = trig_type ^ hwdata_i[NUM_IRQ-1:0];
        end
        edge_next = ((edge_pend & ~clr_mask) | set_mask) & ~type_chg;
    end

    always_comb begin
        hrdata_o = '0;
        if (rd_en) begin
            case (dp_off)
                INTC_ENABLE:  hrdata_o = DWIDTH'(enable);
                INTC_TYPE:    hrdata_o = DWIDTH'(trig_type);
                INTC_PENDING: hrdata_o = DWIDTH'(pending_vec);
                INTC_CLAIM:   hrdata_o = DWIDTH'(claim_val);
                INTC_CTRL:    hrdata_o = DWIDTH'({in_service != '0, ctrl_en});
                default:      hrdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_off     <= '0;
            enable     <= '0;
            trig_type  <= '0;
            edge_pend  <= '0;
            src_d      <= '0;
            ctrl_en    <= 1'b0;
            in_service <= '0;
            irq_o      <= 1'b0;
        end else begin
            src_d     <= irq_src_i;
            edge_pend <= edge_next;
            irq_o     <= ctrl_en & (best_id != '0) & (in_service == '0);
            dp_valid  <= accept;
            if (accept) begin
                dp_write <= hwrite_i;
                dp_off   <= haddr_i[4:2];
            end
            if (wr_en) begin
                case (dp_off)
                    INTC_ENABLE: enable    <= hwdata_i[NUM_IRQ-1:0];
                    INTC_TYPE:   trig_type <= hwdata_i[NUM_IRQ-1:0];
                    INTC_CTRL:   ctrl_en   <= hwdata_i[0];
                    INTC_CLAIM: begin
                        if (in_service != '0 && hwdata_i[INTC_ID_W-1:0] == in_service) begin
                            in_service <= '0;
                        end
                    end
                    default: ;
                endcase
            end
            if (claim_take) begin
                in_service <= best_id;
            end
        end
    end

endmodule
